// File: rtl/vga_frame_reader.sv
// VGA raster timing plus frame-buffer reader; rgb, de and syncs trail the counters by exactly 2 pclk.
// Optional colour-bar generator is compiled in with `define TEST_PATTERN_EN.
module vga_frame_reader #(
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [18:0] rd_addr,
  output logic        rd_en,
  input  logic [11:0] rd_data,
  input  logic        test_sel,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_MAX  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACT);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_MAX  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACT);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACT + V_FP + V_SYNC - 1);
  localparam logic [18:0]   ADDR_LAST = 19'(H_ACT * V_ACT - 1);

  logic          active;
  logic [HW-1:0] hcnt, hcnt_nx;
  logic [VW-1:0] vcnt, vcnt_nx;
  logic          h_wrap, v_wrap, vis_nx, in_hs, in_vs, at_origin;
  logic          vis_d1, hs_d1, vs_d1, fs_d1;
  logic [11:0]   rgb_nx;

  // Counters hold at (0,0) for the first edge after reset so that pixel (0,0)
  // is presented with rd_en high instead of being swallowed by the reset.
  always_comb begin
    h_wrap    = (hcnt == H_MAX);
    v_wrap    = (vcnt == V_MAX);
    hcnt_nx   = hcnt;
    vcnt_nx   = vcnt;
    if (active) begin
      hcnt_nx = h_wrap ? '0 : hcnt + HW'(1);
      if (h_wrap)
        vcnt_nx = v_wrap ? '0 : vcnt + VW'(1);
    end
    vis_nx    = (hcnt_nx < H_VIS) && (vcnt_nx < V_VIS);
    in_hs     = (hcnt >= HS_BEG) && (hcnt <= HS_END);
    in_vs     = (vcnt >= VS_BEG) && (vcnt <= VS_END);
    at_origin = (hcnt == '0) && (vcnt == '0);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      hcnt    <= '0;
      vcnt    <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      active <= 1'b1;
      hcnt   <= hcnt_nx;
      vcnt   <= vcnt_nx;
      rd_en  <= vis_nx;
      if (active && h_wrap && v_wrap)
        rd_addr <= '0;
      else if (rd_en)
        rd_addr <= (rd_addr == ADDR_LAST) ? '0 : rd_addr + 19'd1;
    end
  end

  // Stage 1: aligns timing flags with rd_data coming back from the buffer.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vis_d1 <= 1'b0;
      hs_d1  <= 1'b1;
      vs_d1  <= 1'b1;
      fs_d1  <= 1'b0;
    end else begin
      vis_d1 <= rd_en;
      hs_d1  <= !(active && in_hs);
      vs_d1  <= !(active && in_vs);
      fs_d1  <= active && at_origin;
    end
  end

`ifdef TEST_PATTERN_EN
  localparam logic [HW-1:0] BAR_W = HW'(H_ACT / 8);

  logic [HW-1:0] hcnt_d1;
  logic [2:0]    bar_idx;
  logic [11:0]   bar_rgb;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) hcnt_d1 <= '0;
    else     hcnt_d1 <= hcnt;
  end

  always_comb begin
    bar_idx = 3'(hcnt_d1 / BAR_W);
    case (bar_idx)
      3'd0:    bar_rgb = 12'hFFF;
      3'd1:    bar_rgb = 12'hFF0;
      3'd2:    bar_rgb = 12'h0FF;
      3'd3:    bar_rgb = 12'h0F0;
      3'd4:    bar_rgb = 12'hF0F;
      3'd5:    bar_rgb = 12'hF00;
      3'd6:    bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
    rgb_nx = 12'h000;
    if (vis_d1)
      rgb_nx = test_sel ? bar_rgb : rd_data;
  end
`else
  logic unused_test_sel;
  assign unused_test_sel = test_sel;

  always_comb begin
    rgb_nx = 12'h000;
    if (vis_d1)
      rgb_nx = rd_data;
  end
`endif

  // Stage 2: every video output changes on the same edge.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      rgb         <= 12'h000;
    end else begin
      de          <= vis_d1;
      hsync       <= hs_d1;
      vsync       <= vs_d1;
      frame_start <= fs_d1;
      rgb         <= rgb_nx;
    end
  end

endmodule
